main_menu_input_controller: RTL and testbench



---
 rtl/main_menu_input_controller.sv | 206 ++++++++++++++++++++
 tb/tb_main_menu_input_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_menu_input_controller.sv
// Main-menu input controller: synchronises and debounces five push-buttons, walks the
// two-column menu (0..2 left, 3..4 right) and issues a valid/ready launch request on confirm.
module main_menu_input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       btn_sel_raw,
  input  logic       menu_active,
  output logic [2:0] menu_sel,
  output logic       launch_valid,
  output logic [2:0] launch_mode,
  input  logic       launch_ready
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_SEL   = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_INACTIVE = 2'd0;
  localparam logic [1:0] ST_MENU     = 2'd1;
  localparam logic [1:0] ST_LAUNCH   = 2'd2;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] stable_prev_q;
  logic [NUM_BTN-1:0] armed_q, armed_d;
  logic [NUM_BTN-1:0] press_q;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [1:0]         prime_q;

  logic [1:0] state_q, state_d;
  logic [2:0] menu_sel_q, menu_sel_d;
  logic       valid_q, valid_d;
  logic [2:0] mode_q, mode_d;

  assign btn_raw = {btn_sel_raw, btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw};

  // ---------------------------------------------------------------------------
  // Debounce: the counter runs only while the synced level disagrees with the
  // stable level, and the stable level flips after DEBOUNCE_CYCLES disagreements.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    stable_d = stable_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A button may only produce presses once it has been seen released after reset;
  // prime_q waits until sync2_q holds real samples rather than its reset zeros.
  assign armed_d = armed_q | ({NUM_BTN{prime_q[1]}} & ~sync2_q & ~stable_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      armed_q       <= '0;
      press_q       <= '0;
      prime_q       <= '0;
      // NOTE: the counters are individual flops, not a RAM, so each one is reset explicitly.
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      armed_q       <= armed_d;
      press_q       <= stable_q & ~stable_prev_q & armed_q;
      prime_q       <= {prime_q[0], 1'b1};
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Menu navigation tables
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] nav_up(input logic [2:0] sel);
    case (sel)
      3'd1:    nav_up = 3'd0;
      3'd2:    nav_up = 3'd1;
      3'd4:    nav_up = 3'd3;
      default: nav_up = sel;
    endcase
  endfunction

  function automatic logic [2:0] nav_down(input logic [2:0] sel);
    case (sel)
      3'd0:    nav_down = 3'd1;
      3'd1:    nav_down = 3'd2;
      3'd3:    nav_down = 3'd4;
      default: nav_down = sel;
    endcase
  endfunction

  function automatic logic [2:0] nav_left(input logic [2:0] sel);
    case (sel)
      3'd3:    nav_left = 3'd0;
      3'd4:    nav_left = 3'd1;
      default: nav_left = sel;
    endcase
  endfunction

  function automatic logic [2:0] nav_right(input logic [2:0] sel);
    case (sel)
      3'd0:    nav_right = 3'd3;
      3'd1:    nav_right = 3'd4;
      3'd2:    nav_right = 3'd4;
      default: nav_right = sel;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Menu FSM: one event per cycle, priority sel > up > down > left > right.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    valid_d    = valid_q;
    mode_d     = mode_q;
    case (state_q)
      ST_INACTIVE: begin
        if (menu_active) begin
          state_d    = ST_MENU;
          menu_sel_d = 3'd0;
        end
      end
      ST_MENU: begin
        if (!menu_active) begin
          state_d = ST_INACTIVE;
        end else if (press_q[BTN_SEL]) begin
          mode_d  = menu_sel_q;
          valid_d = 1'b1;
          state_d = ST_LAUNCH;
        end else if (press_q[BTN_UP]) begin
          menu_sel_d = nav_up(menu_sel_q);
        end else if (press_q[BTN_DOWN]) begin
          menu_sel_d = nav_down(menu_sel_q);
        end else if (press_q[BTN_LEFT]) begin
          menu_sel_d = nav_left(menu_sel_q);
        end else if (press_q[BTN_RIGHT]) begin
          menu_sel_d = nav_right(menu_sel_q);
        end
      end
      ST_LAUNCH: begin
        // The request is withdrawn only by the handshake; menu_active is ignored here.
        if (valid_q && launch_ready) begin
          valid_d = 1'b0;
          state_d = ST_INACTIVE;
        end
      end
      default: begin
        state_d = ST_INACTIVE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INACTIVE;
      menu_sel_q <= 3'd0;
      valid_q    <= 1'b0;
      mode_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      menu_sel_q <= menu_sel_d;
      valid_q    <= valid_d;
      mode_q     <= mode_d;
    end
  end

  assign menu_sel     = menu_sel_q;
  assign launch_valid = valid_q;
  assign launch_mode  = mode_q;

  a_sel_range: assert property (@(posedge clock) disable iff (!resetn) menu_sel_q <= 3'd4);

  a_valid_hold: assert property (@(posedge clock) disable iff (!resetn)
    (valid_q && !launch_ready) |=> (valid_q && $stable(mode_q)));

endmodule

// File: tb/tb_main_menu_input_controller.sv
// Bench for main_menu_input_controller: directed test-plan scenarios plus randomized
// button/handshake traffic, compared every cycle against a behavioural menu model.
module tb_main_menu_input_controller;

  localparam int D = 4;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, SEL = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] raw = '0;
  logic       menu_active = 1'b0;
  logic       launch_ready = 1'b0;
  logic [2:0] menu_sel;
  logic       launch_valid;
  logic [2:0] launch_mode;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  main_menu_input_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .btn_up_raw   (raw[UP]),
    .btn_down_raw (raw[DOWN]),
    .btn_left_raw (raw[LEFT]),
    .btn_right_raw(raw[RIGHT]),
    .btn_sel_raw  (raw[SEL]),
    .menu_active  (menu_active),
    .menu_sel     (menu_sel),
    .launch_valid (launch_valid),
    .launch_mode  (launch_mode),
    .launch_ready (launch_ready)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Raw samples are kept as a history word (bit0 = newest); the synchronised level
  // seen at an edge is the sample taken two edges earlier.
  int up_tab    [5] = '{0, 0, 1, 3, 3};
  int down_tab  [5] = '{1, 2, 2, 4, 4};
  int left_tab  [5] = '{0, 1, 2, 0, 1};
  int right_tab [5] = '{3, 4, 4, 3, 4};

  logic [31:0] m_win [5];
  logic [4:0]  m_stb, m_rose, m_arm, m_ev;
  int          m_n;
  int          m_st;     // 0 idle, 1 browsing, 2 request outstanding
  int          m_sel, m_mode;
  bit          m_valid;

  task automatic model_reset();
    for (int b = 0; b < 5; b++) m_win[b] = '0;
    m_stb = '0; m_rose = '0; m_arm = '0; m_ev = '0;
    m_n = 0; m_st = 0; m_sel = 0; m_mode = 0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] nx_ev, nx_rose, nx_arm, nx_stb;
    bit flip;
    for (int b = 0; b < 5; b++) begin
      // stable level flips once the last D synced samples all disagree with it
      flip = 1'b1;
      for (int i = 0; i < D; i++) if (m_win[b][1+i] == m_stb[b]) flip = 1'b0;
      nx_ev[b]   = m_rose[b] & m_arm[b];
      nx_rose[b] = flip & ~m_stb[b];
      nx_arm[b]  = m_arm[b] | (m_n >= 2 && m_win[b][1] == 1'b0 && m_stb[b] == 1'b0);
      nx_stb[b]  = flip ? ~m_stb[b] : m_stb[b];
      m_win[b]   = {m_win[b][30:0], raw[b]};
    end
    case (m_st)
      0: if (menu_active) begin m_st = 1; m_sel = 0; end
      1: begin
        if (!menu_active) m_st = 0;
        else if (m_ev[SEL]) begin m_mode = m_sel; m_valid = 1'b1; m_st = 2; end
        else if (m_ev[UP])    m_sel = up_tab[m_sel];
        else if (m_ev[DOWN])  m_sel = down_tab[m_sel];
        else if (m_ev[LEFT])  m_sel = left_tab[m_sel];
        else if (m_ev[RIGHT]) m_sel = right_tab[m_sel];
      end
      default: if (launch_ready) begin m_valid = 1'b0; m_st = 0; end
    endcase
    m_ev = nx_ev; m_rose = nx_rose; m_arm = nx_arm; m_stb = nx_stb;
    m_n++;
  endtask

  always @(posedge clock) if (resetn) model_step();

  always @(negedge clock) begin
    if (resetn) begin
      check("menu_sel",     8'(menu_sel),     8'(m_sel));
      check("launch_valid", 8'(launch_valid), 8'(m_valid));
      check("launch_mode",  8'(launch_mode),  8'(m_mode));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int cycles);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_menu_sel",     8'(menu_sel),     8'd0);
    check("rst_launch_valid", 8'(launch_valid), 8'd0);
    check("rst_launch_mode",  8'(launch_mode),  8'd0);
    repeat (cycles) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic press(input int b, input int hold, input int gap);
    @(negedge clock);
    raw[b] = 1'b1;
    repeat (hold) @(negedge clock);
    raw[b] = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic accept();
    @(negedge clock);
    launch_ready = 1'b1;
    @(negedge clock);
    launch_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // 1: entry, exact latency, saturation at the bottom of the left column
    repeat (3) @(negedge clock);
    menu_active = 1'b1;
    repeat (3) @(negedge clock);
    check("entry_sel", 8'(menu_sel), 8'd0);
    check("entry_valid", 8'(launch_valid), 8'd0);
    @(negedge clock);
    raw[DOWN] = 1'b1;
    repeat (7) @(negedge clock);
    check("lat_before", 8'(menu_sel), 8'd0);
    @(negedge clock);
    check("lat_at8", 8'(menu_sel), 8'd1);
    repeat (2) @(negedge clock);
    raw[DOWN] = 1'b0;
    repeat (10) @(negedge clock);
    press(DOWN, 10, 10);
    check("down_1_2", 8'(menu_sel), 8'd2);
    press(DOWN, 10, 10);
    check("down_sat", 8'(menu_sel), 8'd2);

    // 2: glitch rejection, single step for a longer press
    press(UP, 3, 10);
    check("glitch", 8'(menu_sel), 8'd2);
    press(UP, 6, 10);
    check("up_once", 8'(menu_sel), 8'd1);

    // 3: two-column navigation
    press(RIGHT, 8, 10); check("right_1_4", 8'(menu_sel), 8'd4);
    press(UP, 8, 10);    check("up_4_3",    8'(menu_sel), 8'd3);
    press(UP, 8, 10);    check("up_sat3",   8'(menu_sel), 8'd3);
    press(LEFT, 8, 10);  check("left_3_0",  8'(menu_sel), 8'd0);
    press(DOWN, 8, 10);
    press(DOWN, 8, 10);  check("down_to2",  8'(menu_sel), 8'd2);
    press(RIGHT, 8, 10); check("right_2_4", 8'(menu_sel), 8'd4);
    press(LEFT, 8, 10);  check("left_4_1",  8'(menu_sel), 8'd1);

    // 4: simultaneous up + sel, sel wins
    @(negedge clock);
    raw[UP] = 1'b1;
    raw[SEL] = 1'b1;
    repeat (8) @(negedge clock);
    raw = '0;
    repeat (10) @(negedge clock);
    check("simul_valid", 8'(launch_valid), 8'd1);
    check("simul_mode",  8'(launch_mode),  8'd1);
    check("simul_sel",   8'(menu_sel),     8'd1);

    // 5: request held without ready while buttons and menu_active move
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      raw[DOWN] = (i < 10);
      menu_active = ((i % 4) < 2);
    end
    repeat (10) @(negedge clock);
    check("hold_valid", 8'(launch_valid), 8'd1);
    check("hold_mode",  8'(launch_mode),  8'd1);
    check("hold_sel",   8'(menu_sel),     8'd1);
    menu_active = 1'b0;
    accept();
    check("accepted", 8'(launch_valid), 8'd0);
    press(DOWN, 8, 10);
    check("idle_ignore_down", 8'(menu_sel), 8'd1);
    press(SEL, 8, 10);
    check("idle_ignore_sel", 8'(launch_valid), 8'd0);

    // 6: reset during a launch of mode 3 with sel still held
    menu_active = 1'b1;
    repeat (3) @(negedge clock);
    check("reenter_sel", 8'(menu_sel), 8'd0);
    press(RIGHT, 8, 10);
    check("right_0_3", 8'(menu_sel), 8'd3);
    @(negedge clock);
    raw[SEL] = 1'b1;
    repeat (10) @(negedge clock);
    check("launch3_valid", 8'(launch_valid), 8'd1);
    check("launch3_mode",  8'(launch_mode),  8'd3);
    do_reset(3);
    repeat (30) @(negedge clock);
    check("no_relaunch", 8'(launch_valid), 8'd0);
    raw[SEL] = 1'b0;
    repeat (12) @(negedge clock);
    press(SEL, 8, 10);
    check("repress_valid", 8'(launch_valid), 8'd1);
    check("repress_mode",  8'(launch_mode),  8'd0);
    accept();
    check("repress_accept", 8'(launch_valid), 8'd0);

    // randomized traffic: glitchy buttons, random ready, occasional menu exits
    for (int it = 0; it < 1500; it++) begin
      @(negedge clock);
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
      if ($urandom_range(0, 49) == 0) menu_active = ~menu_active;
      launch_ready = ($urandom_range(0, 3) == 0);
      if (it == 700) do_reset(2);
    end
    raw = '0;
    launch_ready = 1'b0;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
